// File: rtl/rf_bist.sv
// Register-file self-test controller: writes a seed pattern and its inverse to every
// register, reads them back two per cycle, and reports pass/fail, error count and first failing address.
module rf_bist #(
    parameter int          WIDTH    = 32,
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] SEED     = 32'hA5A55A5A,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [WIDTH-1:0]  wd3,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    input  logic [WIDTH-1:0]  rd1,
    input  logic [WIDTH-1:0]  rd2,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD0  = 3'd2,
        S_WR1  = 3'd3,
        S_RD1  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam int                REP      = (WIDTH + ADDR_W) / ADDR_W;
    localparam logic [WIDTH-1:0]  SEED_W   = WIDTH'(SEED);
    localparam logic [ADDR_W-1:0] WR_LAST  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] RD_LAST  = WR_LAST >> 1'b1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(32'd1);

    // Address replicated across the data word, XORed into the seed.
    function automatic logic [WIDTH-1:0] pat_f(input logic [ADDR_W-1:0] a);
        logic [REP*ADDR_W-1:0] rep;
        rep = {REP{a}};
        return SEED_W ^ rep[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] exp_f(input logic [ADDR_W-1:0] a, input logic inv);
        logic [WIDTH-1:0] e;
        if (ZERO_REG && (a == {ADDR_W{1'b0}})) begin
            e = {WIDTH{1'b0}};
        end else if (inv) begin
            e = ~pat_f(a);
        end else begin
            e = pat_f(a);
        end
        return e;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        err_q, err_d;
    logic [ADDR_W-1:0] fail_q, fail_d;
    logic              pass_q, pass_d;
    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] wa3_q, wa3_d;
    logic [WIDTH-1:0]  wd3_q, wd3_d;
    logic [ADDR_W-1:0] ra1_q, ra1_d;
    logic [ADDR_W-1:0] ra2_q, ra2_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              rd_s, inv_s, mism1_s, mism2_s;
    logic [1:0]        add_s;
    logic [8:0]        sum_s;

    // Next-state, counter and result logic; compares use the registered read addresses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        rd_s    = (state_q == S_RD0) || (state_q == S_RD1);
        inv_s   = (state_q == S_RD1);
        mism1_s = (rd1 != exp_f(ra1_q, inv_s));
        mism2_s = (rd2 != exp_f(ra2_q, inv_s));
        add_s   = {1'b0, mism1_s} + {1'b0, mism2_s};
        sum_s   = {1'b0, err_q} + {7'b0000000, add_s};

        if (rd_s) begin
            err_d = sum_s[8] ? 8'hFF : sum_s[7:0];
            if ((err_q == 8'd0) && (mism1_s || mism2_s)) begin
                fail_d = mism1_s ? ra1_q : ra2_q;
            end else begin
                fail_d = fail_q;
            end
        end else begin
            err_d = err_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR0;
                    cnt_d   = {ADDR_W{1'b0}};
                    err_d   = 8'd0;
                    fail_d  = {ADDR_W{1'b0}};
                    pass_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR0, S_WR1: begin
                if (cnt_q == WR_LAST) begin
                    state_d = (state_q == S_WR0) ? S_RD0 : S_RD1;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + ADDR_ONE;
                end
            end
            S_RD0, S_RD1: begin
                if (cnt_q == RD_LAST) begin
                    state_d = (state_q == S_RD0) ? S_WR1 : S_DONE;
                    cnt_d   = {ADDR_W{1'b0}};
                    pass_d  = (state_q == S_RD1) ? (err_d == 8'd0) : pass_q;
                end else begin
                    cnt_d = cnt_q + ADDR_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Port values for the upcoming cycle, decoded from next state so outputs are flops.
    always_comb begin
        we3_d  = 1'b0;
        wa3_d  = {ADDR_W{1'b0}};
        wd3_d  = {WIDTH{1'b0}};
        ra1_d  = {ADDR_W{1'b0}};
        ra2_d  = {ADDR_W{1'b0}};
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_WR0, S_WR1: begin
                we3_d  = 1'b1;
                wa3_d  = cnt_d;
                wd3_d  = (state_d == S_WR1) ? ~pat_f(cnt_d) : pat_f(cnt_d);
                busy_d = 1'b1;
            end
            S_RD0, S_RD1: begin
                ra1_d  = cnt_d << 1'b1;
                ra2_d  = (cnt_d << 1'b1) | ADDR_ONE;
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any test immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {ADDR_W{1'b0}};
            err_q   <= 8'd0;
            fail_q  <= {ADDR_W{1'b0}};
            pass_q  <= 1'b0;
            we3_q   <= 1'b0;
            wa3_q   <= {ADDR_W{1'b0}};
            wd3_q   <= {WIDTH{1'b0}};
            ra1_q   <= {ADDR_W{1'b0}};
            ra2_q   <= {ADDR_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            we3_q   <= we3_d;
            wa3_q   <= wa3_d;
            wd3_q   <= wd3_d;
            ra1_q   <= ra1_d;
            ra2_q   <= ra2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign we3       = we3_q;
    assign wa3       = wa3_q;
    assign wd3       = wd3_q;
    assign ra1       = ra1_q;
    assign ra2       = ra2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = fail_q;

endmodule

// File: tb/tb_rf_bist.sv
// Directed bench for rf_bist: three controller instances, each beside a small
// register-file model with selectable faults.
module tb_rf_bist;

    localparam int N  = 32;
    localparam int NC = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic start_a, start_b, start_c;
    int   mode;

    logic        we3_a, busy_a, done_a, pass_a;
    logic [4:0]  wa3_a, ra1_a, ra2_a, fail_a;
    logic [31:0] wd3_a, rd1_a, rd2_a;
    logic [7:0]  err_a;

    logic        we3_b, busy_b, done_b, pass_b;
    logic [4:0]  wa3_b, ra1_b, ra2_b, fail_b;
    logic [31:0] wd3_b, rd1_b, rd2_b;
    logic [7:0]  err_b;

    logic        we3_c, busy_c, done_c, pass_c;
    logic [7:0]  wa3_c, ra1_c, ra2_c, fail_c;
    logic [31:0] wd3_c, rd1_c, rd2_c;
    logic [7:0]  err_c;

    logic [31:0] mem_a [N];
    logic [31:0] mem_b [N];

    rf_bist #(.WIDTH(32), .ADDR_W(5), .SEED(32'hA5A55A5A), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a),
        .we3(we3_a), .wa3(wa3_a), .wd3(wd3_a), .ra1(ra1_a), .ra2(ra2_a),
        .rd1(rd1_a), .rd2(rd2_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_addr(fail_a));

    rf_bist #(.WIDTH(32), .ADDR_W(5), .SEED(32'hA5A55A5A), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .we3(we3_b), .wa3(wa3_b), .wd3(wd3_b), .ra1(ra1_b), .ra2(ra2_b),
        .rd1(rd1_b), .rd2(rd2_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_addr(fail_b));

    rf_bist #(.WIDTH(32), .ADDR_W(8), .SEED(32'hA5A55A5A), .ZERO_REG(1'b1)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_c),
        .we3(we3_c), .wa3(wa3_c), .wd3(wd3_c), .ra1(ra1_c), .ra2(ra2_c),
        .rd1(rd1_c), .rd2(rd2_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .fail_addr(fail_c));

    // Model A: mode 0 ideal (r0 reads 0), 1 bit 3 of r7 stuck at 0, 2 r0 writable
    always @(posedge clk) begin
        if (we3_a) mem_a[wa3_a] <= wd3_a;
        if (we3_b) mem_b[wa3_b] <= wd3_b;
    end

    always_comb begin
        rd1_a = mem_a[ra1_a];
        rd2_a = mem_a[ra2_a];
        if (ra1_a == 5'd0 && mode != 2) rd1_a = 32'd0;
        if (ra2_a == 5'd0 && mode != 2) rd2_a = 32'd0;
        if (mode == 1 && ra1_a == 5'd7) rd1_a[3] = 1'b0;
        if (mode == 1 && ra2_a == 5'd7) rd2_a[3] = 1'b0;
    end

    assign rd1_b = mem_b[ra1_b];
    assign rd2_b = mem_b[ra2_b];
    assign rd1_c = 32'd0;
    assign rd2_c = 32'd0;

    int total = 0;
    int bad   = 0;
    logic [31:0] obs_wd1, obs_wd2, obs_wd49, obs_ra1_34, obs_ra2_34;
    logic        obs_we33;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts A and B together and observes A for a fixed window of 3N+10 cycles.
    task automatic run_a(input bit repulse, output int done_at, output int busy_cnt, output int dones);
        start_a = 1'b1;
        start_b = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        done_at = 0;
        busy_cnt = 0;
        dones = 0;
        for (int c = 1; c <= 3 * N + 10; c++) begin
            if (busy_a) busy_cnt++;
            if (done_a) begin
                dones++;
                if (done_at == 0) done_at = c;
            end
            if (c == 1) obs_wd1 = wd3_a;
            if (c == 2) obs_wd2 = wd3_a;
            if (c == 33) obs_we33 = we3_a;
            if (c == 34) begin
                obs_ra1_34 = 32'(ra1_a);
                obs_ra2_34 = 32'(ra2_a);
            end
            if (c == 49) obs_wd49 = wd3_a;
            start_a = repulse && (c == 10 || c == 50);
            tick();
        end
        start_a = 1'b0;
    endtask

    typedef struct {
        int         mode;
        bit         repulse;
        logic       pass;
        logic [7:0] err;
        logic [4:0] fail;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int done_at, busy_cnt, dones;

        tbl[0] = '{mode: 0, repulse: 1'b0, pass: 1'b1, err: 8'd0, fail: 5'd0};
        tbl[1] = '{mode: 1, repulse: 1'b0, pass: 1'b0, err: 8'd1, fail: 5'd7};
        tbl[2] = '{mode: 2, repulse: 1'b0, pass: 1'b0, err: 8'd2, fail: 5'd0};
        tbl[3] = '{mode: 0, repulse: 1'b1, pass: 1'b1, err: 8'd0, fail: 5'd0};

        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        mode    = 0;
        repeat (2) tick();
        chk("rst_we3", 32'(we3_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_pass", 32'(pass_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_fail", 32'(fail_a), 32'd0);
        chk("rst_wd3", wd3_a, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            run_a(tbl[i].repulse, done_at, busy_cnt, dones);
            chk($sformatf("v%0d_done_at", i), 32'(done_at), 32'(3 * N + 1));
            chk($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), 32'(3 * N));
            chk($sformatf("v%0d_done_pulses", i), 32'(dones), 32'd1);
            chk($sformatf("v%0d_pass", i), 32'(pass_a), 32'(tbl[i].pass));
            chk($sformatf("v%0d_err", i), 32'(err_a), 32'(tbl[i].err));
            chk($sformatf("v%0d_fail", i), 32'(fail_a), 32'(tbl[i].fail));
            chk($sformatf("v%0d_b_pass", i), 32'(pass_b), 32'd1);
            chk($sformatf("v%0d_b_err", i), 32'(err_b), 32'd0);
            if (i == 0) begin
                chk("wd3_c1", obs_wd1, 32'hA5A55A5A);
                chk("wd3_c2", obs_wd2, 32'hE7B5DE7B);
                chk("we3_rd0", 32'(obs_we33), 32'd0);
                chk("ra1_c34", obs_ra1_34, 32'd2);
                chk("ra2_c34", obs_ra2_34, 32'd3);
                chk("wd3_wr1_first", obs_wd49, 32'h5A5AA5A5);
            end
        end

        // start in the done cycle is dropped; start in the following idle cycle is taken
        mode = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3 * N) tick();
        chk("seq_done_cycle", 32'(done_a), 32'd1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_in_done_busy", 32'(busy_a), 32'd0);
        chk("start_in_done_done", 32'(done_a), 32'd0);
        run_a(1'b0, done_at, busy_cnt, dones);
        chk("b2b_done_at", 32'(done_at), 32'(3 * N + 1));
        chk("b2b_pass", 32'(pass_a), 32'd1);

        // reset during a write phase drops we3 with no clock edge
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        chk("wr_we3_before", 32'(we3_a), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("wr_rst_we3", 32'(we3_a), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // reset during RD0
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (N + 4) tick();
        chk("rd0_ra1_before", 32'(ra1_a), 32'd8);
        chk("rd0_busy_before", 32'(busy_a), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rd0_rst_we3", 32'(we3_a), 32'd0);
        chk("rd0_rst_busy", 32'(busy_a), 32'd0);
        chk("rd0_rst_ra1", 32'(ra1_a), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 2 * N; c++) begin
            if (done_a || busy_a) dones++;
            tick();
        end
        chk("rd0_rst_no_done", 32'(dones), 32'd0);
        run_a(1'b0, done_at, busy_cnt, dones);
        chk("after_rst_done_at", 32'(done_at), 32'(3 * N + 1));
        chk("after_rst_pass", 32'(pass_a), 32'd1);
        chk("after_rst_err", 32'(err_a), 32'd0);

        // all reads zero on a 256-entry file: error count saturates
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        done_at = 0;
        for (int c = 1; c <= 3 * NC + 20; c++) begin
            if (done_c && done_at == 0) done_at = c;
            tick();
        end
        chk("sat_done_at", 32'(done_at), 32'(3 * NC + 1));
        chk("sat_err", 32'(err_c), 32'd255);
        chk("sat_fail", 32'(fail_c), 32'd1);
        chk("sat_pass", 32'(pass_c), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
